// File: rtl/fetch_controller.sv
// PC sequencer and single-port instruction memory arbiter (fetch vs loader).
// Optional fetch counter enabled by defining FETCH_CTRL_PERF_EN.
module fetch_controller #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 24
) (
  input  logic               CLK,
  input  logic               reset_n,
  input  logic [PC_W-1:0]    immediate,
  input  logic               PCSrc,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               start,
  input  logic               ld_valid,
  input  logic [PC_W-1:0]    ld_addr,
  input  logic [INSTR_W-1:0] ld_data,
  output logic               ld_ready,
  output logic [PC_W-1:0]    mem_addr,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] Instr,
  output logic               instr_valid,
  output logic [1:0]         state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]        fetch_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BOOT;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ld_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = ld_addr;
    Instr       = '0;
    instr_valid = 1'b0;
    case (state_q)
      BOOT, HALT: begin
        ld_ready = 1'b1;
        // write must vanish the instant reset is asserted
        mem_we   = ld_valid & reset_n;
        if (start) begin
          state_d = RUN;
          if (state_q == BOOT) pc_d = '0;
        end
      end
      RUN: begin
        mem_addr    = pc_q;
        Instr       = mem_rdata;
        instr_valid = !stall;
        if (halt_req) begin
          state_d = HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (PCSrc) begin
          pc_d = immediate;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign mem_wdata = ld_data;
  assign PC        = pc_q;
  assign state     = state_q;

`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) fcnt_q <= '0;
    else          fcnt_q <= fcnt_d;
  end

  always_comb begin
    fcnt_d = fcnt_q;
    if (state_q == BOOT && start)
      fcnt_d = '0;
    else if (instr_valid && fcnt_q != 16'hFFFF)
      fcnt_d = fcnt_q + 16'd1;
  end

  assign fetch_count = fcnt_q;
`endif

endmodule
